id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
- ID/EX pipeline stage of the five-stage MIPS core; sits directly downstream of the general control decoder.
- Each cycle it registers the decoded EX/MEM/WB control bundles, operands, immediate and register addresses for the EX stage.
- Detects load-use hazards; stalls IF/ID and inserts a bubble.
- Inserts a bubble on branch/jump flush and counts stall cycles for performance monitoring.

Parameters:
DATA_W, 32, register operand width
IMM_W, 16, raw immediate width; sign-extended to DATA_W
CNT_W, 16, stall counter width

Ports:
clk_i  in  1  clock; all state updates on rising edge
rst_i  in  1  synchronous, active-high reset
id_valid_i  in  1  ID holds a real instruction
id_EX_ctrl_i  in  4  {ALUop[1:0], ALUsrc, RegDst}
id_MEM_ctrl_i  in  2  {MEM_cs, MEM_we}
id_WB_ctrl_i  in  1  writeback source: 1 = ALU, 0 = memory
id_rs_data_i  in  DATA_W  rs register value
id_rt_data_i  in  DATA_W  rt register value
id_imm_i  in  IMM_W  raw immediate
id_rs_addr_i  in  5  rs index
id_rt_addr_i  in  5  rt index
id_rd_addr_i  in  5  rd index
id_uses_rt_i  in  1  instruction reads rt as a source (R-type, SW, BEQ)
flush_i  in  1  kill the instruction in ID (taken branch/jump)
stall_o  out  1  hold PC and IF/ID this cycle (combinational)
ex_valid_o  out  1  EX holds a real instruction
ex_EX_ctrl_o  out  4  registered EX control
ex_MEM_ctrl_o  out  2  registered MEM control
ex_WB_ctrl_o  out  1  registered WB control
ex_rs_data_o  out  DATA_W  registered rs value
ex_rt_data_o  out  DATA_W  registered rt value
ex_imm_o  out  DATA_W  sign-extended immediate
ex_rs_addr_o  out  5  registered rs index (for forwarding)
ex_rt_addr_o  out  5  registered rt index
ex_dst_addr_o  out  5  resolved destination register
stall_cnt_o  out  CNT_W  saturating count of stall cycles

Behaviour:
- Reset: on a clock edge with rst_i=1, every registered output clears to 0, including stall_cnt_o. A reset mid-stall or mid-flush wins unconditionally. stall_o is 0 whenever ex_valid_o=0.
- Load in EX: load_ex = ex_valid_o & (ex_MEM_ctrl_o == 2'b10).
- Hazard: hazard = id_valid_i & load_ex & (ex_rt_addr_o != 0) & ((ex_rt_addr_o == id_rs_addr_i) | (id_uses_rt_i & (ex_rt_addr_o == id_rt_addr_i))).
- Stall output: stall_o = hazard & ~flush_i. Flush has priority: a killed instruction never stalls.
- Next-state selection, evaluated in this priority order on each edge:
  1. rst_i: clear all registers.
  2. flush_i | hazard | ~id_valid_i: insert a bubble. ex_valid_o=0; all ctrl, data, imm and addr outputs = 0.
  3. Otherwise: load all ID inputs. ex_valid_o=1. ex_imm_o = {{(DATA_W-IMM_W){id_imm_i[IMM_W-1]}}, id_imm_i}.
- Destination resolution, registered with the instruction:
  - If id_MEM_ctrl_i[1]=1 (LW/SW): ex_dst_addr_o = id_rt_addr_i. The RegDst bit is ignored here because it is undriven for these opcodes.
  - Else if RegDst=1: ex_dst_addr_o = id_rd_addr_i.
  - Else: ex_dst_addr_o = id_rt_addr_i.
- Undriven control inputs: any control input bit that is not 0/1 while loading is registered as 0.
- Stall length: a load-use stall lasts exactly one cycle. The bubble removes the load from EX, so hazard deasserts on the next cycle. Upstream holds ID, and the dependent instruction loads on the following edge.
- Back-to-back loads: a load followed by a dependent load stalls once. Two independent loads do not stall.
- Stall counter: stall_cnt_o increments by 1 on every edge where stall_o=1. It saturates at 2^CNT_W-1 and never wraps.
- Latency: 1 cycle from ID inputs to ex_* outputs. stall_o is combinational from the current ex_* state and the ID inputs.

Test Plan:
- Reset: apply garbage inputs with rst_i=1 for 2 cycles -> all outputs 0, stall_o=0, stall_cnt_o=0.
- ADDI pass-through: id_valid_i=1, EX_ctrl={ADD,1,1}, imm=16'hFFF0, rt=7 -> next cycle ex_imm_o=32'hFFFFFFF0, ex_dst_addr_o=7 (RegDst=1 selects rd; set rd=7), ex_valid_o=1.
- Load-use: LW with rt=5 then ADD with rs=5 -> stall_o=1 for exactly 1 cycle, one bubble (ex_valid_o=0), ADD enters EX the following cycle, stall_cnt_o=1.
- r0 and non-use:
  - LW rt=0 then ADD rs=0 -> no stall.
  - LW rt=5 then ADDI with rt=5 and id_uses_rt_i=0 -> no stall.
- Flush versus hazard: hazard condition with flush_i=1 -> stall_o=0, bubble inserted, stall_cnt_o unchanged.
- Saturation: CNT_W=2, force 5 consecutive load-use pairs -> stall_cnt_o sequence 1, 2, 3, 3, 3. Then assert rst_i mid-stall -> next edge all zero.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the five-stage MIPS core: registers the decoded
// bundle for EX, detects load-use hazards, inserts bubbles and counts stall cycles.
module id_ex_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IMM_W  = 16,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  input  logic [3:0]        id_EX_ctrl_i,
  input  logic [1:0]        id_MEM_ctrl_i,
  input  logic              id_WB_ctrl_i,
  input  logic [DATA_W-1:0] id_rs_data_i,
  input  logic [DATA_W-1:0] id_rt_data_i,
  input  logic [IMM_W-1:0]  id_imm_i,
  input  logic [4:0]        id_rs_addr_i,
  input  logic [4:0]        id_rt_addr_i,
  input  logic [4:0]        id_rd_addr_i,
  input  logic              id_uses_rt_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic              ex_valid_o,
  output logic [3:0]        ex_EX_ctrl_o,
  output logic [1:0]        ex_MEM_ctrl_o,
  output logic              ex_WB_ctrl_o,
  output logic [DATA_W-1:0] ex_rs_data_o,
  output logic [DATA_W-1:0] ex_rt_data_o,
  output logic [DATA_W-1:0] ex_imm_o,
  output logic [4:0]        ex_rs_addr_o,
  output logic [4:0]        ex_rt_addr_o,
  output logic [4:0]        ex_dst_addr_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  typedef struct packed {
    logic              valid;
    logic [3:0]        ex_ctrl;
    logic [1:0]        mem_ctrl;
    logic              wb_ctrl;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic [4:0]        rs_addr;
    logic [4:0]        rt_addr;
    logic [4:0]        dst_addr;
  } ex_bundle_t;

  ex_bundle_t       ex_q, ex_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic       load_ex;
  logic       hazard;
  logic       bubble;
  logic [3:0] ex_ctrl_clean;
  logic [1:0] mem_ctrl_clean;
  logic       wb_ctrl_clean;

  always_comb begin
    load_ex = ex_q.valid & (ex_q.mem_ctrl == 2'b10);
    hazard  = id_valid_i & load_ex & (ex_q.rt_addr != 5'd0)
            & ((ex_q.rt_addr == id_rs_addr_i)
               | (id_uses_rt_i & (ex_q.rt_addr == id_rt_addr_i)));
    bubble  = flush_i | hazard | ~id_valid_i;
  end

  // Flush wins: an instruction being killed must never hold up the front end.
  assign stall_o = hazard & ~flush_i;

  // Control bits that are not a clean 1 (0, X or Z) are registered as 0.
  always_comb begin
    for (int i = 0; i < 4; i++) ex_ctrl_clean[i] = (id_EX_ctrl_i[i] === 1'b1);
    for (int i = 0; i < 2; i++) mem_ctrl_clean[i] = (id_MEM_ctrl_i[i] === 1'b1);
    wb_ctrl_clean = (id_WB_ctrl_i === 1'b1);
  end

  // NOTE: every variable gets a default at the top of a combinational block so
  // no path can leave it unassigned and infer a latch.
  always_comb begin
    ex_d = '0;
    if (!bubble) begin
      ex_d.valid    = 1'b1;
      ex_d.ex_ctrl  = ex_ctrl_clean;
      ex_d.mem_ctrl = mem_ctrl_clean;
      ex_d.wb_ctrl  = wb_ctrl_clean;
      ex_d.rs_data  = id_rs_data_i;
      ex_d.rt_data  = id_rt_data_i;
      ex_d.imm      = {{(DATA_W-IMM_W){id_imm_i[IMM_W-1]}}, id_imm_i};
      ex_d.rs_addr  = id_rs_addr_i;
      ex_d.rt_addr  = id_rt_addr_i;
      // LW/SW target rt regardless of RegDst, which the decoder leaves undriven.
      if (mem_ctrl_clean[1])     ex_d.dst_addr = id_rt_addr_i;
      else if (ex_ctrl_clean[0]) ex_d.dst_addr = id_rd_addr_i;
      else                       ex_d.dst_addr = id_rt_addr_i;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_o && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign ex_valid_o    = ex_q.valid;
  assign ex_EX_ctrl_o  = ex_q.ex_ctrl;
  assign ex_MEM_ctrl_o = ex_q.mem_ctrl;
  assign ex_WB_ctrl_o  = ex_q.wb_ctrl;
  assign ex_rs_data_o  = ex_q.rs_data;
  assign ex_rt_data_o  = ex_q.rt_data;
  assign ex_imm_o      = ex_q.imm;
  assign ex_rs_addr_o  = ex_q.rs_addr;
  assign ex_rt_addr_o  = ex_q.rt_addr;
  assign ex_dst_addr_o = ex_q.dst_addr;
  assign stall_cnt_o   = stall_cnt_q;

endmodule
